// File: rtl/bcd_to_bin_seq_if.sv
// bcd_to_bin_seq_if: start/busy/done handshake with the BCD input and binary result
interface bcd_to_bin_seq_if #(parameter int DIGITS = 3, parameter int BIN_W = 10);
  logic                start;
  logic [4*DIGITS-1:0] bcd;
  logic                busy;
  logic                done;
  logic                err;
  logic [BIN_W-1:0]    bin;
  modport master (output start, bcd, input busy, done, err, bin);
  modport slave  (input start, bcd, output busy, done, err, bin);
endinterface

// File: rtl/bcd_to_bin_seq.sv
// bcd_to_bin_seq: sequential BCD-to-binary converter (reverse double-dabble)
module bcd_to_bin_seq #(
  parameter int DIGITS = 3,
  parameter int BIN_W  = 10
) (
  input  logic clk,
  input  logic rst_n,
  bcd_to_bin_seq_if.slave bus
);
  localparam int BW = 4*DIGITS;
  localparam int SW = BW + BIN_W;
  localparam int CW = $clog2(BIN_W + 1);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t        state;
  logic [SW-1:0] sr, sh, fixed;
  logic [CW-1:0] cnt;
  logic          bad;
  // fields >=8 after the shift get 3 removed, each field independently
  always_comb begin
    sh    = sr >> 1;
    fixed = sh;
    bad   = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      fixed[BIN_W+4*i +: 4] = sh[BIN_W+4*i +: 4] >= 4'd8 ? sh[BIN_W+4*i +: 4] - 4'd3 : sh[BIN_W+4*i +: 4];
      bad = bad | (bus.bcd[4*i +: 4] > 4'd9);
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      sr       <= '0;
      cnt      <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.err  <= 1'b0;
      bus.bin  <= '0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          bus.busy <= 1'b1;
          if (bad) begin
            bus.done <= 1'b1;
            bus.err  <= 1'b1;
            bus.bin  <= '0;
            state    <= DONE;
          end else begin
            sr    <= {bus.bcd, {BIN_W{1'b0}}};
            cnt   <= '0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          sr  <= fixed;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(BIN_W-1)) begin
            bus.bin  <= fixed[BIN_W-1:0];
            bus.err  <= 1'b0;
            bus.done <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: begin
          bus.done <= 1'b0;
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// tb_bcd_to_bin_seq: vector table plus directed sequences for handshake, reset abort and full sweep
module tb_bcd_to_bin_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_bad = 0;
  bcd_to_bin_seq_if #(.DIGITS(3), .BIN_W(10)) bus ();
  bcd_to_bin_seq #(.DIGITS(3), .BIN_W(10)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] bcd;
    logic [9:0]  bin;
    logic        err;
    int          lat;
  } vec_t;
  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic conv(input logic [11:0] b, output int lat);
    @(negedge clk);
    bus.bcd   = b;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    lat = 1;
    while (!bus.done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    int lat, ndone, got_bin, cyc, last, i;
    bit drop;
    vecs[0]  = '{12'h999, 10'd999, 1'b0, 11};
    vecs[1]  = '{12'h000, 10'd0,   1'b0, 11};
    vecs[2]  = '{12'h255, 10'd255, 1'b0, 11};
    vecs[3]  = '{12'h100, 10'd100, 1'b0, 11};
    vecs[4]  = '{12'h1A3, 10'd0,   1'b1, 1};
    vecs[5]  = '{12'h042, 10'd42,  1'b0, 11};
    vecs[6]  = '{12'h009, 10'd9,   1'b0, 11};
    vecs[7]  = '{12'h090, 10'd90,  1'b0, 11};
    vecs[8]  = '{12'h900, 10'd900, 1'b0, 11};
    vecs[9]  = '{12'h00A, 10'd0,   1'b1, 1};
    vecs[10] = '{12'h888, 10'd888, 1'b0, 11};
    vecs[11] = '{12'hF00, 10'd0,   1'b1, 1};
    vecs[12] = '{12'h518, 10'd518, 1'b0, 11};
    vecs[13] = '{12'h321, 10'd321, 1'b0, 11};
    bus.start = 1'b0;
    bus.bcd   = '0;
    repeat (2) @(negedge clk);
    chk("reset_outputs", {bus.busy, bus.done, bus.err, bus.bin}, 0);
    rst_n = 1'b1;
    for (int v = 0; v < 14; v++) begin
      conv(vecs[v].bcd, lat);
      chk($sformatf("lat_%03h", vecs[v].bcd), lat, vecs[v].lat);
      chk($sformatf("bin_%03h", vecs[v].bcd), bus.bin, vecs[v].bin);
      chk($sformatf("err_%03h", vecs[v].bcd), bus.err, vecs[v].err);
      chk($sformatf("busy_in_done_%03h", vecs[v].bcd), bus.busy, 1);
      @(negedge clk);
      chk($sformatf("done_pulse_%03h", vecs[v].bcd), {bus.done, bus.busy}, 0);
    end
    // start/bcd re-asserted during SHIFT and DONE must be ignored
    @(negedge clk);
    bus.bcd = 12'h512;
    bus.start = 1'b1;
    @(negedge clk);
    bus.bcd = 12'h777;
    ndone = 0;
    got_bin = 0;
    drop = 1'b0;
    for (int c = 0; c < 30; c++) begin
      if (drop) begin
        bus.start = 1'b0;
        drop = 1'b0;
      end
      if (bus.done) begin
        ndone++;
        got_bin = int'(bus.bin);
        drop = 1'b1;
      end
      @(negedge clk);
    end
    chk("ignore_start_ndone", ndone, 1);
    chk("ignore_start_bin", got_bin, 512);
    // reset in the middle of a conversion aborts it
    @(negedge clk);
    bus.bcd = 12'h999;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("abort_outputs", {bus.busy, bus.done, bus.err, bus.bin}, 0);
    ndone = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.done) ndone++;
    end
    rst_n = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (bus.done) ndone++;
    end
    chk("abort_no_done", ndone, 0);
    conv(12'h123, lat);
    chk("after_abort_lat", lat, 11);
    chk("after_abort_bin", bus.bin, 123);
    // full sweep, start held high, one done every 12 cycles
    @(negedge clk);
    @(negedge clk);
    i = 0;
    bus.bcd = to_bcd(0);
    bus.start = 1'b1;
    cyc = 0;
    last = 0;
    while (i < 1000 && cyc < 13000) begin
      @(negedge clk);
      cyc++;
      if (bus.done) begin
        chk($sformatf("sweep_bin_%0d", i), bus.bin, i);
        chk($sformatf("sweep_err_%0d", i), bus.err, 0);
        if (i > 0) chk($sformatf("sweep_gap_%0d", i), cyc - last, 12);
        last = cyc;
        i++;
        bus.bcd = to_bcd(i < 1000 ? i : 0);
      end
    end
    bus.start = 1'b0;
    chk("sweep_complete", i, 1000);
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
    $finish;
  end
endmodule
